// File: rtl/zd_pkg.sv
// Shared types and constants for the zero-detect scheduler.
package zd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } zd_state_t;

    localparam int unsigned SLICE_W = 16;

endpackage

// File: rtl/or_16bit.sv
// 16-input OR reduction; purely combinational, sampled only at clock edges.
module or_16bit (
    input  logic [15:0] in_i,
    output logic        or_o
);

    assign or_o = |in_i;

endmodule

// File: rtl/zero_detect_sched.sv
// Round-robin scheduler sharing one 16-bit OR tree between requesters that
// need a zero test on a WIDTH-bit operand, scanned one slice per cycle.
module zero_detect_sched
    import zd_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned NREQ       = 2,
    parameter int unsigned EARLY_EXIT = 1,
    localparam int unsigned ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  operand,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic                   done_zero
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH == 0) begin : g_width_chk
        $error("zero_detect_sched: WIDTH must be a non-zero multiple of 16");
    end
    if (NREQ < 2 || NREQ > 4) begin : g_nreq_chk
        $error("zero_detect_sched: NREQ must be in 2..4");
    end

    zd_state_t              state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [WIDTH-1:0]       op_q, op_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   acc_q, acc_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic                   done_q, done_d;
    logic [ID_W-1:0]        done_id_q, done_id_d;
    logic                   done_zero_q, done_zero_d;

    logic [WIDTH-1:0]       ops_c    [NREQ];
    logic [SLICE_W-1:0]     slices_c [NSLICE];
    logic [ID_W-1:0]        win_c;
    logic                   win_found_c;
    logic                   or_out_c;
    logic                   scan_end_c;

    for (genvar g = 0; g < NREQ; g++) begin : g_ops
        assign ops_c[g] = operand[g*WIDTH +: WIDTH];
    end

    for (genvar s = 0; s < NSLICE; s++) begin : g_slices
        assign slices_c[s] = op_q[s*SLICE_W +: SLICE_W];
    end

    or_16bit u_or (
        .in_i (slices_c[idx_q]),
        .or_o (or_out_c)
    );

    assign scan_end_c = (idx_q == IDX_W'(NSLICE - 1)) || ((EARLY_EXIT != 0) && or_out_c);

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_c       = '0;
        win_found_c = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!win_found_c && req[(32'(rr_ptr_q) + k) % NREQ]) begin
                win_c       = ID_W'((32'(rr_ptr_q) + k) % NREQ);
                win_found_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (|req)      state_d = SCAN;
            SCAN: if (scan_end_c) state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        gnt_d       = '0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        done_zero_d = done_zero_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    op_d     = ops_c[win_c];
                    id_d     = win_c;
                    gnt_d    = NREQ'(1) << win_c;
                    rr_ptr_d = (win_c == ID_W'(NREQ - 1)) ? '0 : win_c + ID_W'(1);
                    idx_d    = '0;
                    acc_d    = 1'b0;
                end
            end
            SCAN: begin
                acc_d = acc_q | or_out_c;
                if (scan_end_c) begin
                    done_d      = 1'b1;
                    done_id_d   = id_q;
                    done_zero_d = ~(acc_q | or_out_c);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            acc_q       <= 1'b0;
            gnt_q       <= '0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            done_zero_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            done_zero_q <= done_zero_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q == SCAN);
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign done_zero = done_zero_q;

endmodule

// File: tb/tb_zero_detect_sched.sv
// Scoreboard bench: transaction-level round-robin/zero-test model feeding a
// queue that an independent monitor drains on every done pulse.
module tb_zero_detect_sched;

    logic          clk;
    logic          reset_n;
    logic [1:0]    req;
    logic [63:0]   opv [2];
    logic [127:0]  operand;
    logic [1:0]    gnt;
    logic          busy, done, done_zero;
    logic [0:0]    done_id;

    logic [1:0]    req_b;
    logic [63:0]   opv_b [2];
    logic [127:0]  operand_b;
    logic [1:0]    gnt_b;
    logic          busy_b, done_b, done_zero_b;
    logic [0:0]    done_id_b;

    assign operand   = {opv[1], opv[0]};
    assign operand_b = {opv_b[1], opv_b[0]};

    zero_detect_sched #(.WIDTH(64), .NREQ(2), .EARLY_EXIT(1)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .operand(operand),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .done_zero(done_zero)
    );

    zero_detect_sched #(.WIDTH(64), .NREQ(2), .EARLY_EXIT(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_b), .operand(operand_b),
        .gnt(gnt_b), .busy(busy_b), .done(done_b), .done_id(done_id_b), .done_zero(done_zero_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit zero;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   rr_m  = 0;
    int   cyc   = 0;
    int   gnt_cyc = 0;

    // Cycles from acceptance to done: first non-zero 16-bit slice k gives k+1
    // with early exit; otherwise the full four slices.
    function automatic int exp_lat(input logic [63:0] op, input int ee);
        for (int k = 0; k < 4; k++) begin
            if (((op >> (16 * k)) & 64'hFFFF) != 64'h0) return (ee != 0) ? k + 1 : 4;
        end
        return 4;
    endfunction

    function automatic int pick(input logic [1:0] r, input int rr);
        for (int k = 0; k < 2; k++) begin
            if (r[(rr + k) % 2]) return (rr + k) % 2;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rand_op();
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0: v = 64'h0;
            1: v = 64'($urandom_range(1, 16'hFFFF)) << (16 * $urandom_range(0, 3));
            2: v = {$urandom, $urandom};
            default: v = 64'h1 << $urandom_range(0, 63);
        endcase
        return v;
    endfunction

    task automatic check(input string name, input int act, input int req_v);
        n_vec++;
        if (act != req_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req_v, $time);
        end
    endtask

    task automatic raise(input logic [1:0] bits, input logic [63:0] o0, input logic [63:0] o1);
        @(negedge clk);
        if (bits[0]) begin opv[0] = o0; req[0] = 1'b1; end
        if (bits[1]) begin opv[1] = o1; req[1] = 1'b1; end
    endtask

    // Predict the next grant, push its result, then complete the handshake.
    task automatic serve(input logic [1:0] late, input logic [63:0] late_op);
        int   w;
        bit   got;
        exp_t e;
        w = pick(req, rr_m);
        if (w < 0) return;
        e.id   = w;
        e.zero = (opv[w] == 64'h0);
        e.lat  = exp_lat(opv[w], 1);
        sb.push_back(e);
        rr_m = (w + 1) % 2;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (gnt != 2'b00) got = 1'b1;
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL gnt_timeout: no grant seen, expected gnt for id %0d", w);
        end else begin
            check("gnt_onehot", int'(gnt), 1 << w);
        end
        req[w] = 1'b0;
        opv[w] = (e.zero) ? 64'hFFFF : rand_op();
        for (int i = 0; i < 2; i++) begin
            if (late[i] && !req[i]) begin
                opv[i] = late_op;
                req[i] = 1'b1;
            end
        end
    endtask

    task automatic check_b(input int lane, input logic [63:0] op);
        bit got;
        int d;
        @(negedge clk);
        opv_b[lane] = op;
        req_b[lane] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (gnt_b != 2'b00) got = 1'b1;
        end
        req_b = 2'b00;
        opv_b[lane] = 64'hFFFF;
        check("b_gnt", int'(gnt_b), got ? (1 << lane) : -1);
        d = 0;
        got = 1'b0;
        while (d < 20 && !got) begin
            @(negedge clk);
            d++;
            if (done_b) got = 1'b1;
        end
        check("b_latency", got ? d : -1, exp_lat(op, 0));
        check("b_done_id", int'(done_id_b), lane);
        check("b_done_zero", int'(done_zero_b), (op == 64'h0) ? 1 : 0);
    endtask

    // Monitor: pops one expectation per done pulse, checks overlap and latency.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (gnt != 2'b00) gnt_cyc = cyc;
        if (reset_n && (gnt != 2'b00 || done)) begin
            n_vec++;
            if (gnt != 2'b00 && done) begin
                n_err++;
                $display("FAIL overlap: gnt=%b done=%b in same cycle", gnt, done);
            end
        end
        if (reset_n && done) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: done_id=%0d with nothing outstanding", done_id);
            end else begin
                e = sb.pop_front();
                n_err = n_err + ((int'(done_id) != e.id) ? 1 : 0);
                if (int'(done_id) != e.id)
                    $display("FAIL done_id: got %0d expected %0d", done_id, e.id);
                n_vec++;
                if (done_zero != e.zero) begin
                    n_err++;
                    $display("FAIL done_zero: got %0d expected %0d (id %0d)", done_zero, e.zero, e.id);
                end
                n_vec++;
                if (cyc - gnt_cyc != e.lat) begin
                    n_err++;
                    $display("FAIL latency: got %0d expected %0d (id %0d)", cyc - gnt_cyc, e.lat, e.id);
                end
            end
        end
    end

    initial begin
        bit got;
        reset_n  = 1'b0;
        req      = 2'b00;
        req_b    = 2'b00;
        opv[0]   = '0; opv[1]   = '0;
        opv_b[0] = '0; opv_b[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_id", int'(done_id), 0);
        check("rst_done_zero", int'(done_zero), 0);
        reset_n = 1'b1;

        // Reset in the middle of a scan aborts without a result.
        @(negedge clk);
        opv[0] = 64'h0;
        req[0] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (gnt != 2'b00) got = 1'b1;
        end
        req[0] = 1'b0;
        check("abort_gnt", int'(gnt), got ? 1 : -1);
        @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("abort_gnt0", int'(gnt), 0);
        check("abort_busy0", int'(busy), 0);
        check("abort_done0", int'(done), 0);
        check("abort_done_id0", int'(done_id), 0);
        check("abort_done_zero0", int'(done_zero), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rr_m = 0;
        repeat (6) @(negedge clk);

        // Contention: grants 0,1,0 (requester 0 re-requests after its grant).
        raise(2'b11, 64'h0, 64'h0);
        serve(2'b01, 64'h0);
        serve(2'b00, 64'h0);
        serve(2'b00, 64'h0);
        // Single zero operand, then early-exit operand on requester 1.
        raise(2'b01, 64'h0, 64'h0);
        serve(2'b00, 64'h0);
        raise(2'b10, 64'h0, 64'h0000_0001_0000_0000);
        serve(2'b00, 64'h0);
        // Late request during a scan is granted once the scan completes.
        raise(2'b01, 64'h0, 64'h0);
        serve(2'b10, 64'h0);
        serve(2'b00, 64'h0);

        // Full scan regardless of content when early exit is off.
        check_b(0, 64'h0000_0001_0000_0000);
        check_b(1, 64'h1);
        check_b(0, 64'h0);

        for (int it = 0; it < 200; it++) begin
            if (req == 2'b00) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                raise(2'($urandom_range(1, 3)), rand_op(), rand_op());
            end
            serve(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, rand_op());
        end

        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (sb.size() == 0) got = 1'b1;
        end
        check("drain_outstanding", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
